// File: rtl/qcl_scratchpad_loader.sv
// Fill stage for a 1-read-all/1-write scratchpad: turns a valid/ready word stream
// into sequential write commands and holds the frame until the consumer releases it.
module qcl_scratchpad_loader #(
    parameter int width_p = 32,
    parameter int els_p   = 16,
    localparam int addr_width_lp  = $clog2(els_p),
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      last_i,
    output logic                      ready_o,
    output logic                      w_en_o,
    output logic [addr_width_lp-1:0]  addr_o,
    output logic [width_p-1:0]        data_o,
    output logic                      full_o,
    output logic [count_width_lp-1:0] count_o,
    input  logic                      release_i
);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_e;

    state_e                    state_q, state_d;
    logic [addr_width_lp-1:0]  wptr_q, wptr_d;
    logic                      w_en_q, w_en_d;
    logic [addr_width_lp-1:0]  addr_q, addr_d;
    logic [width_p-1:0]        data_q, data_d;
    logic                      full_q, full_d;
    logic [count_width_lp-1:0] count_q, count_d;

    logic                      accept;
    logic                      flush;
    logic [addr_width_lp-1:0]  wptr_eff;
    logic                      final_word;

    assign ready_o    = (state_q == IDLE) || (state_q == FILL);
    assign accept     = v_i & ready_o;
    assign flush      = release_i & ready_o;
    // A flush in the same cycle as an accept restarts the frame with this word at addr 0.
    assign wptr_eff   = flush ? '0 : wptr_q;
    assign final_word = last_i || (wptr_eff == addr_width_lp'(els_p - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            w_en_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            full_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            w_en_q  <= w_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            full_q  <= full_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        w_en_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        full_d  = full_q;
        count_d = count_q;
        case (state_q)
            IDLE, FILL: begin
                if (flush) begin
                    wptr_d  = '0;
                    state_d = IDLE;
                end
                if (accept) begin
                    w_en_d = 1'b1;
                    addr_d = wptr_eff;
                    data_d = data_i;
                    if (final_word) begin
                        state_d = COMMIT;
                        count_d = count_width_lp'(wptr_eff) + count_width_lp'(1);
                        wptr_d  = '0;
                    end else begin
                        state_d = FILL;
                        wptr_d  = wptr_eff + addr_width_lp'(1);
                    end
                end
            end
            COMMIT: begin
                state_d = DONE;
                full_d  = 1'b1;
            end
            DONE: begin
                if (release_i) begin
                    state_d = IDLE;
                    full_d  = 1'b0;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_en_o  = w_en_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign full_o  = full_q;
    assign count_o = count_q;

endmodule

// File: doc/qcl_scratchpad_loader.md
Name: qcl_scratchpad_loader

Overview:
Upstream fill stage for the 1-read-all/1-write scratchpad. It accepts a valid/ready word stream and converts it into sequential scratchpad write commands (w_en/addr/data), starting at address 0. It closes a frame on `last_i` or on reaching `els_p` words, then signals the consumer that the frame is committed. Input stays stalled until the consumer releases the frame after snapshotting the scratchpad's parallel output.

Parameters:
- width_p, 32, data word width; must match the scratchpad width_p.
- els_p, 16, scratchpad depth in words; must be >= 2.
- addr_width_lp, $clog2(els_p), local; write address width.
- count_width_lp, $clog2(els_p+1), local; frame word-count width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- v_i  in  1  input word valid.
- data_i  in  width_p  input word.
- last_i  in  1  marks the final word of a frame; qualified by v_i.
- ready_o  out  1  loader can accept a word this cycle.
- w_en_o  out  1  scratchpad write enable (registered).
- addr_o  out  addr_width_lp  scratchpad write address (registered).
- data_o  out  width_p  scratchpad write data (registered).
- full_o  out  1  frame committed; scratchpad contents are stable.
- count_o  out  count_width_lp  number of words in the committed frame; valid while full_o=1.
- release_i  in  1  consumer done with the frame / flush request.

Behaviour:
- Interface: one clock, clk_i; reset_i is asynchronous and active-high.
- Reset values: state=IDLE, wptr=0, w_en_o=0, addr_o=0, data_o=0, full_o=0, count_o=0; therefore ready_o=1.
- Reset mid-frame discards the partial frame; contents already written to the scratchpad are not cleared.
- States: IDLE, FILL, COMMIT, DONE.
- ready_o = 1 when state is IDLE or FILL; 0 in COMMIT and DONE. ready_o is a function of state only.
- Accept occurs when v_i & ready_o.
- Write latency is 1 cycle. An accept at edge N gives w_en_o=1, addr_o=wptr, data_o=data_i during cycle N+1.
  - w_en_o is a single-cycle pulse per accepted word.
  - addr_o and data_o hold their last values when w_en_o=0.
- wptr is internal and addr_width_lp wide. It increments by 1 per accept.
- Final word: the accepted word is final when last_i=1 or wptr==els_p-1.
  - On a final accept: state -> COMMIT, count_o <= wptr+1, wptr <= 0.
  - No wrap-around: word els_p-1 always closes the frame, even if last_i=0.
- Non-final accept: IDLE -> FILL, or stay in FILL.
- COMMIT lasts exactly one cycle; the final w_en_o pulse is in this cycle. Then state -> DONE and full_o <= 1.
  - Result: full_o first rises in the cycle after the final write commits to the scratchpad.
- DONE: full_o=1 and count_o is held. release_i=1 -> IDLE next cycle with full_o=0 and count_o=0, so ready_o=1 one cycle after release.
- release_i in IDLE or FILL (flush):
  - wptr <= 0, state -> IDLE.
  - If an accept occurs in the same cycle, flush wins for the pointer: the word is written to addr 0 and wptr <= 1, state -> FILL (or COMMIT if last_i=1).
- release_i in COMMIT is ignored.
- A single-word frame (last_i on the first word) gives count_o=1.
- Data on v_i while ready_o=0 is not consumed; upstream must hold it.

Test Plan:
- Full frame, els_p=4, continuous v_i with data 0xA0..0xA3 and last_i=0:
  - w_en_o pulses with addr 0,1,2,3 on the cycles following each accept.
  - ready_o drops the cycle after the 4th accept.
  - full_o=1 one cycle after the addr 3 write; count_o=4.
- Short frame, els_p=16: 3 words with last_i on 0xC2.
  - Writes go to addr 0..2; count_o=3; full_o=1 two cycles after the 3rd accept.
  - release_i pulse -> full_o=0 and ready_o=1 next cycle.
  - The next frame's first word goes to addr 0.
- Backpressure: hold v_i=1 with 0xDD while in DONE for 5 cycles.
  - No w_en_o during that time.
  - After release_i, 0xDD is written once, to addr 0.
- Flush with simultaneous accept: after 2 words in FILL, assert release_i together with v_i=1 and data 0x55.
  - 0x55 is written to addr 0; the next word goes to addr 1; full_o stays 0.
- Async reset mid-frame: assert reset_i between edges after 2 accepts.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After deassertion, the next word is written to addr 0.
- Randomized valid gaps and random last_i, with a scoreboard of the expected frame:
  - Every write address is sequential from 0.
  - count_o equals the number of words written.
  - Never more than els_p writes per frame.
